// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps each instruction through fetch/execute/writeback via en/ready handshakes.
// Optional stage watchdog is built when STAGE_TIMEOUT_EN is defined.
module instr_sequencer #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16,
  parameter logic [1:0]      OP_NOP   = 2'b00,
  parameter logic [1:0]      OP_LOD   = 2'b01,
  parameter logic [1:0]      OP_JMP   = 2'b10,
  parameter logic [1:0]      OP_ADD   = 2'b11
`ifdef STAGE_TIMEOUT_EN
  , parameter int unsigned   TIMEOUT_CYC = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             halt_req,
  output logic             fetch_en,
  input  logic             fetch_ready,
  input  logic [7:0]       instr,
  output logic             exec_en,
  input  logic             exec_ready,
  output logic             wb_en,
  input  logic             wb_ready,
  output logic [1:0]       op,
  output logic             srcdst,
  output logic [4:0]       operand,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] retired,
  output logic             busy,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

  state_t     state;
  state_t     state_next;
  state_t     after_retire;
  logic       armed;
  logic       stage_ready;
  logic       complete;
  logic       retire;
  logic       entering;
  logic       timeout;
  logic [1:0] new_op;
  logic [4:0] new_operand;
  logic       is_halt_instr;

  assign new_op        = instr[7:6];
  assign new_operand   = instr[4:0];
  assign is_halt_instr = (new_op == OP_NOP) && (new_operand == 5'h1F);

`ifdef STAGE_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wd_cnt;

  assign timeout = (state == S_FETCH || state == S_EXEC || state == S_WB) && !complete &&
                   (wd_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  // A ready seen in the first cycle of a state is stale from the previous enable.
  always_comb begin
    stage_ready = 1'b0;
    case (state)
      S_FETCH: stage_ready = fetch_ready;
      S_EXEC:  stage_ready = exec_ready;
      S_WB:    stage_ready = wb_ready;
      default: stage_ready = 1'b0;
    endcase
  end

  assign complete = armed && stage_ready;
  assign retire   = complete && ((state == S_WB) ||
                    (state == S_FETCH && (new_op == OP_NOP || new_op == OP_JMP)));

  always_comb begin
    after_retire = S_FETCH;
    if (state == S_FETCH && is_halt_instr)
      after_retire = S_HALT;
    else if (halt_req || !run)
      after_retire = S_IDLE;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (run && !halt_req) state_next = S_FETCH;
      S_FETCH: if (complete)
                 state_next = (new_op == OP_LOD || new_op == OP_ADD) ? S_EXEC : after_retire;
      S_EXEC:  if (complete) state_next = S_WB;
      S_WB:    if (complete) state_next = after_retire;
      default: state_next = S_HALT;
    endcase
    if (timeout)
      state_next = S_HALT;
  end

  // A retire that refetches re-enters FETCH, so it must re-arm like a real state change.
  assign entering = (state_next != state) || retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      pc       <= RESET_PC;
      retired  <= '0;
      op       <= 2'b00;
      srcdst   <= 1'b0;
      operand  <= 5'd0;
      fetch_en <= 1'b0;
      exec_en  <= 1'b0;
      wb_en    <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
`ifdef STAGE_TIMEOUT_EN
      wd_cnt   <= '0;
      fault    <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      armed    <= !entering;
      fetch_en <= (state_next == S_FETCH);
      exec_en  <= (state_next == S_EXEC);
      wb_en    <= (state_next == S_WB);
      busy     <= (state_next == S_FETCH) || (state_next == S_EXEC) || (state_next == S_WB);
      halted   <= (state_next == S_HALT);
      if (state == S_FETCH && complete) begin
        op      <= new_op;
        srcdst  <= instr[5];
        operand <= new_operand;
        pc      <= (new_op == OP_JMP) ? PC_W'(new_operand) : pc + PC_W'(1);
      end
      if (retire)
        retired <= retired + CNT_W'(1);
`ifdef STAGE_TIMEOUT_EN
      wd_cnt <= entering ? '0 : wd_cnt + TO_W'(1);
      if (timeout)
        fault <= 1'b1;
`endif
    end
  end

endmodule
